sd_wrrmux: RTL and testbench
============================

// Module: sd_wrrmux
// PURPOSE
//  N-input srdy/drdy weighted-round-robin arbiter/mux, parametrised successor of the 2-input WRR mux.
//  Each input gets up to c_weight[i] grants per round, visited in cyclic order. Grant is locked under
//  backpressure and, in packet mode, until end-of-packet. Sits in forks/ between N producers and one consumer.
// PARAMETERS
//  width      8   data bits per input
//  inputs     4   number of input channels (>=2); idx_sz = $clog2(inputs)
//  weight_sz  4   bits per weight field; weight 0 is treated as 1
//  pkt_mode   0   0: credit and grant per word; 1: credit and grant per packet (c_eop delimits)
// PORTS
//  clk       in   1                 clock, all state on posedge
//  reset     in   1                 asynchronous, ACTIVE-LOW reset (asserted when 0)
//  c_data    in   width*inputs      input i data at [i*width +: width]
//  c_weight  in   weight_sz*inputs  input i weight at [i*weight_sz +: weight_sz]
//  c_eop     in   inputs            end-of-packet per input (ignored when pkt_mode=0)
//  c_srdy    in   inputs            input valid
//  c_drdy    out  inputs            input ready; = p_grant & {inputs{p_drdy}}
//  p_data    out  width             selected input data
//  p_eop     out  1                 c_eop of selected input
//  p_grant   out  inputs            one-hot selected input, 0 when p_srdy=0
//  p_srdy    out  1                 = |c_srdy
//  p_drdy    in   1                 consumer ready
// BEHAVIOUR
//  State: cur[idx_sz] (round-robin start), cred[i][weight_sz] (remaining credit), lock, lock_idx.
//  Reset (reset==0, async): cur=0, all cred=0, lock=0. Outputs are combinational:
//   with c_srdy=0, p_srdy=0, p_grant=0, c_drdy=0, p_data=c_data[0].
//  Latency: zero cycles, combinational path from c_* to p_* and from p_drdy to c_drdy.
//  Transfer on input i = c_srdy[i] & c_drdy[i].
//  Selection (lock=0): winner = first i, scanning cyclically from cur (inclusive), with c_srdy[i] & cred[i]!=0.
//   If none has credit but some input requests, this is a new round: winner = first requester from cur.
//  Selection (lock=1): winner = lock_idx. If c_srdy[lock_idx]=0 (protocol violation), the lock is
//   ignored and the lock=0 rule applies.
//  Credit update on a counted event. Counted event = any transfer (pkt_mode=0), or a transfer with
//   c_eop=1 (pkt_mode=1).
//   - new round: all cred[j] <= max(c_weight[j],1); then cred[winner] <= max(c_weight[winner],1)-1.
//   - otherwise: cred[winner] <= cred[winner]-1.
//   - cur <= winner if its resulting cred != 0, else (winner+1) mod inputs.
//   Weights are sampled only at round reload; changing c_weight mid-round affects the next round.
//  The new-round decision is made at the first word of the packet.
//  Lock next cycle:
//   - lock <= 1, lock_idx <= winner when p_srdy & ~p_drdy, so grant and p_data hold until transfer.
//   - pkt_mode=1: also lock when a transfer occurs with c_eop=0 (mid-packet).
//   - lock <= 0 on a counted event, or when p_srdy=0 and not mid-packet.
//  No bubbles: a new winner can be granted in the cycle after the previous counted event.
//  A single requester transfers every cycle whenever p_drdy=1, regardless of credit (rounds reload).
//  Reset asserted mid-packet or mid-stall clears lock, cur and cred immediately; no state survives.
// TESTING
//  1 inputs=3, weights 2,1,3, all srdy, p_drdy=1 -> p_grant order 0,0,1,2,2,2,0,0,1 (one-hot per cycle).
//  2 only ch0 srdy, p_drdy=0 for 3 cycles; ch1 raises srdy in cycle 2
//    -> p_grant=0001 and p_data stable all 3 cycles; ch0 transfers when p_drdy=1, then ch1 granted.
//  3 weights 0,0,0,0, all srdy -> strict round robin 0,1,2,3,0 (weight 0 acts as 1).
//  4 pkt_mode=1, ch0 sends a 3-word packet (eop on word 3), ch1 srdy throughout, weights 1,1
//    -> words 0,0,0 from ch0 then ch1, no interleave; credit decrements once per packet.
//  5 only ch2 srdy, weight 1, p_drdy=1 for 5 cycles -> 5 consecutive transfers, c_drdy=0100 every cycle.
//  6 reset=0 while locked mid-packet on ch2 -> lock=0, cur=0, cred=0 immediately;
//    after release, with all srdy, ch0 wins.

Source files
------------

// File: rtl/sd_wrrmux.sv
// N-input srdy/drdy weighted-round-robin arbiter/mux. The grant stays locked under
// backpressure and, in packet mode, until end-of-packet.
module sd_wrrmux #(
    parameter int unsigned width     = 8,
    parameter int unsigned inputs    = 4,
    parameter int unsigned weight_sz = 4,
    parameter int unsigned pkt_mode  = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [width*inputs-1:0]     c_data,
    input  logic [weight_sz*inputs-1:0] c_weight,
    input  logic [inputs-1:0]           c_eop,
    input  logic [inputs-1:0]           c_srdy,
    output logic [inputs-1:0]           c_drdy,
    output logic [width-1:0]            p_data,
    output logic                        p_eop,
    output logic [inputs-1:0]           p_grant,
    output logic                        p_srdy,
    input  logic                        p_drdy
);
    localparam int unsigned idx_sz = $clog2(inputs);
    localparam bit          PKT    = (pkt_mode != 0);

    logic [idx_sz-1:0]    r_cur;
    logic [idx_sz-1:0]    r_lock_idx;
    logic                 r_lock;
    logic                 r_midpkt;
    logic [weight_sz-1:0] r_cred [inputs];

    int unsigned          w_scan;
    logic [idx_sz-1:0]    w_sidx;
    logic                 w_found;
    logic [idx_sz-1:0]    w_cred_win;
    logic                 w_rr_found;
    logic [idx_sz-1:0]    w_rr_win;
    logic                 w_lock_ok;
    logic [idx_sz-1:0]    w_win;
    logic [idx_sz-1:0]    w_next;
    logic                 w_new_round;
    logic                 w_xfer;
    logic                 w_eop_sel;
    logic                 w_count;
    logic [weight_sz-1:0] w_reload [inputs];
    logic [weight_sz-1:0] w_res;

    always_comb begin
        for (int unsigned j = 0; j < inputs; j++) begin
            w_reload[j] = c_weight[j*weight_sz +: weight_sz];
            if (w_reload[j] == '0)
                w_reload[j] = weight_sz'(1);
        end
    end

    // Cyclic scan from r_cur: first credited requester, and first requester at all.
    always_comb begin
        w_scan     = '0;
        w_sidx     = '0;
        w_found    = 1'b0;
        w_cred_win = '0;
        w_rr_found = 1'b0;
        w_rr_win   = '0;
        for (int unsigned k = 0; k < inputs; k++) begin
            w_scan = (k + 32'(r_cur)) % inputs;
            w_sidx = w_scan[idx_sz-1:0];
            if (!w_found && c_srdy[w_sidx] && (r_cred[w_sidx] != '0)) begin
                w_found    = 1'b1;
                w_cred_win = w_sidx;
            end
            if (!w_rr_found && c_srdy[w_sidx]) begin
                w_rr_found = 1'b1;
                w_rr_win   = w_sidx;
            end
        end
    end

    // Credits only change on counted events, so a locked winner that was picked as a
    // new round still has zero credit when its counted event arrives.
    always_comb begin
        w_lock_ok = r_lock & c_srdy[r_lock_idx];
        if (w_lock_ok) begin
            w_win       = r_lock_idx;
            w_new_round = (r_cred[r_lock_idx] == '0);
        end else if (w_found) begin
            w_win       = w_cred_win;
            w_new_round = 1'b0;
        end else begin
            w_win       = w_rr_win;
            w_new_round = w_rr_found;
        end
        w_next = (w_win == idx_sz'(inputs - 1)) ? '0 : w_win + idx_sz'(1);
    end

    always_comb begin
        p_srdy  = |c_srdy;
        p_grant = '0;
        if (p_srdy)
            p_grant[w_win] = 1'b1;
        p_data    = c_data[32'(w_win)*width +: width];
        w_eop_sel = c_eop[w_win];
        p_eop     = w_eop_sel;
        c_drdy    = p_grant & {inputs{p_drdy}};
        w_xfer    = p_srdy & p_drdy;
        w_count   = w_xfer & (!PKT | w_eop_sel);
        w_res     = (w_new_round ? w_reload[w_win] : r_cred[w_win]) - weight_sz'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur      <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_midpkt   <= 1'b0;
            for (int unsigned j = 0; j < inputs; j++)
                r_cred[j] <= '0;
        end else begin
            if (w_count) begin
                if (w_new_round)
                    for (int unsigned j = 0; j < inputs; j++)
                        r_cred[j] <= w_reload[j];
                r_cred[w_win] <= w_res;
                r_cur         <= (w_res != '0) ? w_win : w_next;
            end
            if (p_srdy && !p_drdy) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_win;
            end else if (PKT && w_xfer && !w_eop_sel) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_win;
                r_midpkt   <= 1'b1;
            end else if (w_count) begin
                r_lock   <= 1'b0;
                r_midpkt <= 1'b0;
            end else if (!p_srdy && !r_midpkt) begin
                r_lock <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sd_wrrmux.sv
// Scoreboard bench for sd_wrrmux: three instances (4-input word mode, 3-input word mode,
// 4-input packet mode) exercised by one task per scenario.
module tb_sd_wrrmux;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [31:0] a_data;  logic [15:0] a_weight; logic [3:0] a_eop, a_srdy, a_cdrdy, a_grant;
    logic [7:0]  a_pdata; logic a_peop, a_psrdy, a_pdrdy;
    logic [23:0] b_data;  logic [11:0] b_weight; logic [2:0] b_eop, b_srdy, b_cdrdy, b_grant;
    logic [7:0]  b_pdata; logic b_peop, b_psrdy, b_pdrdy;
    logic [31:0] k_data;  logic [15:0] k_weight; logic [3:0] k_eop, k_srdy, k_cdrdy, k_grant;
    logic [7:0]  k_pdata; logic k_peop, k_psrdy, k_pdrdy;

    sd_wrrmux #(.width(8), .inputs(4), .weight_sz(4), .pkt_mode(0)) u_dut (
        .clk(clk), .reset(reset), .c_data(a_data), .c_weight(a_weight), .c_eop(a_eop),
        .c_srdy(a_srdy), .c_drdy(a_cdrdy), .p_data(a_pdata), .p_eop(a_peop),
        .p_grant(a_grant), .p_srdy(a_psrdy), .p_drdy(a_pdrdy));

    sd_wrrmux #(.width(8), .inputs(3), .weight_sz(4), .pkt_mode(0)) u_dut3 (
        .clk(clk), .reset(reset), .c_data(b_data), .c_weight(b_weight), .c_eop(b_eop),
        .c_srdy(b_srdy), .c_drdy(b_cdrdy), .p_data(b_pdata), .p_eop(b_peop),
        .p_grant(b_grant), .p_srdy(b_psrdy), .p_drdy(b_pdrdy));

    sd_wrrmux #(.width(8), .inputs(4), .weight_sz(4), .pkt_mode(1)) u_pkt (
        .clk(clk), .reset(reset), .c_data(k_data), .c_weight(k_weight), .c_eop(k_eop),
        .c_srdy(k_srdy), .c_drdy(k_cdrdy), .p_data(k_pdata), .p_eop(k_peop),
        .p_grant(k_grant), .p_srdy(k_psrdy), .p_drdy(k_pdrdy));

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] data;
        logic       eop;
        logic [3:0] drdy;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic apply_reset();
        a_srdy = '0; b_srdy = '0; k_srdy = '0;
        a_eop  = '0; b_eop  = '0; k_eop  = '0;
        a_pdrdy = 1'b1; b_pdrdy = 1'b1; k_pdrdy = 1'b1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        a_srdy = '0; a_pdrdy = 1'b1; a_eop = '0; a_weight = 16'h1111;
        a_data = 32'h44332211;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (a_psrdy !== 1'b0) begin
            n_errors++; $display("FAIL reset_psrdy: got %b expected 0", a_psrdy);
        end
        n_checks++;
        if (a_grant !== 4'b0000) begin
            n_errors++; $display("FAIL reset_grant: got %b expected 0000", a_grant);
        end
        n_checks++;
        if (a_cdrdy !== 4'b0000) begin
            n_errors++; $display("FAIL reset_cdrdy: got %b expected 0000", a_cdrdy);
        end
        n_checks++;
        if (a_pdata !== 8'h11) begin
            n_errors++; $display("FAIL reset_pdata: got %h expected 11", a_pdata);
        end
    endtask

    task automatic test_weighted();
        int unsigned order [9] = '{0, 0, 1, 2, 2, 2, 0, 0, 1};
        logic [7:0]  d [3];
        apply_reset();
        b_weight = {4'd3, 4'd1, 4'd2};
        b_eop = '0; b_pdrdy = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) d[i] = 8'($urandom);
            b_data = {d[2], d[1], d[0]};
            b_srdy = 3'b111;
            e.grant = 4'(1 << order[c]); e.data = d[order[c]]; e.eop = 1'b0; e.drdy = e.grant;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({1'b0, b_grant} !== e.grant || b_pdata !== e.data || b_peop !== e.eop ||
                {1'b0, b_cdrdy} !== e.drdy) begin
                n_errors++;
                $display("FAIL weighted[%0d]: grant=%b data=%h drdy=%b expected grant=%b data=%h drdy=%b",
                         c, b_grant, b_pdata, b_cdrdy, e.grant, e.data, e.drdy);
            end
        end
        b_srdy = '0;
    endtask

    task automatic test_stall();
        logic [3:0] srdy_t [5] = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0011};
        logic       drdy_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int         ch_t   [5] = '{0, 0, 0, 0, 1};
        logic [7:0] d [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
        apply_reset();
        a_weight = 16'h1111; a_eop = '0;
        a_data = {d[3], d[2], d[1], d[0]};
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            a_srdy = srdy_t[c]; a_pdrdy = drdy_t[c];
            e.grant = 4'(1 << ch_t[c]); e.data = d[ch_t[c]]; e.eop = 1'b0;
            e.drdy = drdy_t[c] ? e.grant : 4'b0000;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (a_grant !== e.grant || a_pdata !== e.data || a_cdrdy !== e.drdy) begin
                n_errors++;
                $display("FAIL stall[%0d]: grant=%b data=%h drdy=%b expected grant=%b data=%h drdy=%b",
                         c, a_grant, a_pdata, a_cdrdy, e.grant, e.data, e.drdy);
            end
        end
        a_srdy = '0; a_pdrdy = 1'b1;
    endtask

    task automatic test_zero_weight();
        int unsigned order [5] = '{0, 1, 2, 3, 0};
        logic [7:0]  d [4];
        apply_reset();
        a_weight = 16'h0000; a_eop = '0; a_pdrdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
            a_data = {d[3], d[2], d[1], d[0]};
            a_srdy = 4'b1111;
            e.grant = 4'(1 << order[c]); e.data = d[order[c]]; e.eop = 1'b0; e.drdy = e.grant;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (a_grant !== e.grant || a_pdata !== e.data || a_cdrdy !== e.drdy) begin
                n_errors++;
                $display("FAIL zero_weight[%0d]: grant=%b data=%h drdy=%b expected grant=%b data=%h drdy=%b",
                         c, a_grant, a_pdata, a_cdrdy, e.grant, e.data, e.drdy);
            end
        end
        a_srdy = '0;
    endtask

    task automatic test_packet();
        logic [3:0] srdy_t [5] = '{4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0011};
        logic [3:0] eop_t  [5] = '{4'b0010, 4'b0010, 4'b0011, 4'b0010, 4'b0010};
        int         ch_t   [5] = '{0, 0, 0, 1, 0};
        logic [7:0] d [4];
        apply_reset();
        k_weight = 16'h1111; k_pdrdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
            k_data = {d[3], d[2], d[1], d[0]};
            k_srdy = srdy_t[c]; k_eop = eop_t[c];
            e.grant = 4'(1 << ch_t[c]); e.data = d[ch_t[c]]; e.eop = eop_t[c][ch_t[c]];
            e.drdy = e.grant;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (k_grant !== e.grant || k_pdata !== e.data || k_peop !== e.eop || k_cdrdy !== e.drdy) begin
                n_errors++;
                $display("FAIL packet[%0d]: grant=%b data=%h eop=%b drdy=%b expected grant=%b data=%h eop=%b drdy=%b",
                         c, k_grant, k_pdata, k_peop, k_cdrdy, e.grant, e.data, e.eop, e.drdy);
            end
        end
        k_srdy = '0; k_eop = '0;
    endtask

    task automatic test_single();
        logic [7:0] d [4];
        apply_reset();
        a_weight = 16'h1111; a_eop = '0; a_pdrdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
            a_data = {d[3], d[2], d[1], d[0]};
            a_srdy = 4'b0100;
            e.grant = 4'b0100; e.data = d[2]; e.eop = 1'b0; e.drdy = 4'b0100;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (a_grant !== e.grant || a_pdata !== e.data || a_cdrdy !== e.drdy) begin
                n_errors++;
                $display("FAIL single[%0d]: grant=%b data=%h drdy=%b expected grant=%b data=%h drdy=%b",
                         c, a_grant, a_pdata, a_cdrdy, e.grant, e.data, e.drdy);
            end
        end
        a_srdy = '0;
    endtask

    task automatic test_reset_midpkt();
        logic [3:0] srdy_t [2] = '{4'b0100, 4'b0101};
        logic [7:0] d [4];
        apply_reset();
        k_weight = 16'h1111; k_pdrdy = 1'b1; k_eop = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
            k_data = {d[3], d[2], d[1], d[0]};
            k_srdy = srdy_t[c];
            e.grant = 4'b0100; e.data = d[2]; e.eop = 1'b0; e.drdy = 4'b0100;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (k_grant !== e.grant || k_pdata !== e.data || k_cdrdy !== e.drdy) begin
                n_errors++;
                $display("FAIL midpkt_lock[%0d]: grant=%b data=%h drdy=%b expected grant=%b data=%h drdy=%b",
                         c, k_grant, k_pdata, k_cdrdy, e.grant, e.data, e.drdy);
            end
        end
        #2;
        reset = 1'b0;
        k_srdy = 4'b1111;
        e.grant = 4'b0001; e.data = d[0]; e.eop = 1'b0; e.drdy = 4'b0001;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        n_checks++;
        if (k_grant !== e.grant || k_pdata !== e.data || k_cdrdy !== e.drdy) begin
            n_errors++;
            $display("FAIL midpkt_in_reset: grant=%b data=%h drdy=%b expected grant=%b data=%h drdy=%b",
                     k_grant, k_pdata, k_cdrdy, e.grant, e.data, e.drdy);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        k_data = {d[3], d[2], d[1], d[0]};
        k_eop = 4'b1111;
        @(negedge clk);
        reset = 1'b1;
        e.grant = 4'b0001; e.data = d[0]; e.eop = 1'b1; e.drdy = 4'b0001;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        n_checks++;
        if (k_grant !== e.grant || k_pdata !== e.data || k_peop !== e.eop || k_cdrdy !== e.drdy) begin
            n_errors++;
            $display("FAIL midpkt_after_reset: grant=%b data=%h eop=%b drdy=%b expected grant=%b data=%h eop=%b drdy=%b",
                     k_grant, k_pdata, k_peop, k_cdrdy, e.grant, e.data, e.eop, e.drdy);
        end
        k_srdy = '0; k_eop = '0;
    endtask

    initial begin
        reset = 1'b0;
        a_data = '0; a_weight = '0; a_eop = '0; a_srdy = '0; a_pdrdy = 1'b1;
        b_data = '0; b_weight = '0; b_eop = '0; b_srdy = '0; b_pdrdy = 1'b1;
        k_data = '0; k_weight = '0; k_eop = '0; k_srdy = '0; k_pdrdy = 1'b1;
        test_reset();
        test_weighted();
        test_stall();
        test_zero_weight();
        test_packet();
        test_single();
        test_reset_midpkt();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
